// File: rtl/hpmevent_ctrl_pkg.sv
// Shared constants and types for the HPM event-select / overflow controller.
// Optional overflow/filter feature is enabled by defining HPM_OVERFLOW_EN.
package hpmevent_ctrl_pkg;
   localparam logic [11:0] MHPMEVENTBASE  = 12'h320;
   localparam logic [11:0] MHPMEVENTHBASE = 12'h720;
   localparam logic [11:0] MIP            = 12'h344;

   localparam int unsigned OF        = 63;
   localparam int unsigned MINH      = 62;
   localparam int unsigned SINH      = 61;
   localparam int unsigned UINH      = 60;
   localparam int unsigned LCOFI_BIT = 13;

   // Wide enough for the largest event bus (64 events)
   localparam int unsigned SELMAX_W = 6;

   typedef enum logic [1:0] {
      PRIV_U    = 2'd0,
      PRIV_S    = 2'd1,
      PRIV_RSVD = 2'd2,
      PRIV_M    = 2'd3
   } priv_e;

   typedef struct packed {
      logic                of;
      logic                minh;
      logic                sinh;
      logic                uinh;
      logic [SELMAX_W-1:0] sel;
   } hpm_evt_t;
endpackage

// File: rtl/hpmevent_ctrl_if.sv
// CSR, event and increment signals of the HPM event controller.
// master = privileged unit / event sources, slave = hpmevent_ctrl.
interface hpmevent_ctrl_if #(
   parameter int XLEN       = 64,
   parameter int COUNTERS   = 32,
   parameter int NUM_EVENTS = 32
);
   logic                  CSRMWriteM;
   logic [11:0]           CSRAdrM;
   logic [XLEN-1:0]       CSRWriteValM;
   logic [1:0]            PrivilegeModeW;
   logic [NUM_EVENTS-1:0] RawEventM;
   logic [COUNTERS-1:0]   CounterWrapM;
   logic [COUNTERS-1:0]   HPMEventIncM;
   logic [XLEN-1:0]       HPMEventReadValM;
   logic                  IllegalHPMEventAccessM;
   logic                  LCOFIPendingM;

   modport master (
      output CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW, RawEventM, CounterWrapM,
      input  HPMEventIncM, HPMEventReadValM, IllegalHPMEventAccessM, LCOFIPendingM
   );

   modport slave (
      input  CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW, RawEventM, CounterWrapM,
      output HPMEventIncM, HPMEventReadValM, IllegalHPMEventAccessM, LCOFIPendingM
   );
endinterface

// File: rtl/hpmevent_ctrl_reg.sv
// Per-counter mhpmevent state: WARL select, mode filter, increment flop, OF set.
// OF/inhibit bits exist only when HPM_OVERFLOW_EN is defined.
module hpmevent_reg
   import hpmevent_ctrl_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NUM_EVENTS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  writeLo,
   input  logic                  writeHi,
   input  logic [XLEN-1:0]       writeVal,
   input  logic [1:0]            privMode,
   input  logic [NUM_EVENTS-1:0] rawEvent,
   input  logic                  wrap,
   output hpm_evt_t              state,
   output logic                  firstWrap,
   output logic                  incReq
);
   localparam int unsigned EW     = $clog2(NUM_EVENTS);
   localparam int unsigned SELTOP = (XLEN == 64) ? 59 : 31;

   hpm_evt_t      next;
   logic [EW-1:0] selIdx;
   logic          selLegal;
   logic          flagWrite;
   logic          inhibit;

   // Any set bit above the select field makes the value out of range
   assign selLegal  = ~|writeVal[SELTOP:EW];
   assign flagWrite = (XLEN == 64) ? writeLo : writeHi;
   assign selIdx    = state.sel[EW-1:0];
   assign inhibit   = ((privMode == PRIV_M) & state.minh) |
                      ((privMode == PRIV_S) & state.sinh) |
                      ((privMode == PRIV_U) & state.uinh);
   assign firstWrap = wrap & ~state.of;

   always_comb begin
      next = state;
      if (writeLo) begin
         next.sel = '0;
         if (selLegal) next.sel[EW-1:0] = writeVal[EW-1:0];
      end
`ifdef HPM_OVERFLOW_EN
      if (flagWrite) {next.of, next.minh, next.sinh, next.uinh} = writeVal[XLEN-1 -: 4];
      // A wrap in the same cycle wins over a software clear of OF
      if (wrap) next.of = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= '0;
         incReq <= 1'b0;
      end else begin
         state  <= next;
         incReq <= rawEvent[selIdx] & (selIdx != '0) & ~inhibit;
      end
   end
endmodule

// File: rtl/hpmevent_ctrl.sv
// HPM event controller top: CSR decode, read mux, LCOFI pending flag.
// Define HPM_OVERFLOW_EN for OF/inhibit bits, mhpmeventh CSRs and LCOFI.
module hpmevent_ctrl
   import hpmevent_ctrl_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int COUNTERS   = 32,
   parameter int NUM_EVENTS = 32
) (
   input logic              clk,
   input logic              reset,
   hpmevent_ctrl_if.slave   hpm
);
   localparam int unsigned EW = $clog2(NUM_EVENTS);

   hpm_evt_t            evState [COUNTERS];
   logic [COUNTERS-1:0] incVec;
   logic [COUNTERS-1:0] firstWrap;
   logic [4:0]          idx;
   logic                idxOk, inLo, inHi, hiEn, isMip, isM, legal, writeEn;
   hpm_evt_t            rd;

`ifdef HPM_OVERFLOW_EN
   assign hiEn = (XLEN == 32);
`else
   assign hiEn = 1'b0;
`endif

   assign idx     = hpm.CSRAdrM[4:0];
   assign idxOk   = (idx >= 5'd3) && (int'(idx) < COUNTERS);
   assign inLo    = (hpm.CSRAdrM[11:5] == MHPMEVENTBASE[11:5]) && idxOk;
   assign inHi    = hiEn && (hpm.CSRAdrM[11:5] == MHPMEVENTHBASE[11:5]) && idxOk;
   assign isMip   = (hpm.CSRAdrM == MIP);
   assign isM     = (hpm.PrivilegeModeW == PRIV_M);
   assign legal   = isM && (inLo || inHi);
   assign writeEn = hpm.CSRMWriteM && legal;

   assign hpm.IllegalHPMEventAccessM = ~isMip & ~legal;

   for (genvar i = 0; i < COUNTERS; i++) begin : g_ctr
      if (i < 3) begin : g_fixed
         assign evState[i]   = '0;
         assign incVec[i]    = 1'b0;
         assign firstWrap[i] = 1'b0;
      end else begin : g_prog
         hpmevent_reg #(.XLEN(XLEN), .NUM_EVENTS(NUM_EVENTS)) u_reg (
            .clk      (clk),
            .reset    (reset),
            .writeLo  (writeEn && inLo && (idx == 5'(i))),
            .writeHi  (writeEn && inHi && (idx == 5'(i))),
            .writeVal (hpm.CSRWriteValM),
            .privMode (hpm.PrivilegeModeW),
            .rawEvent (hpm.RawEventM),
            .wrap     (hpm.CounterWrapM[i]),
            .state    (evState[i]),
            .firstWrap(firstWrap[i]),
            .incReq   (incVec[i])
         );
      end
   end

   assign hpm.HPMEventIncM = incVec;

   always_comb begin
      rd = evState[idx];
      hpm.HPMEventReadValM = '0;
      if (legal) begin
         if (inHi) begin
            hpm.HPMEventReadValM[XLEN-1 -: 4] = {rd.of, rd.minh, rd.sinh, rd.uinh};
         end else begin
            hpm.HPMEventReadValM[EW-1:0] = rd.sel[EW-1:0];
            if (XLEN == 64) hpm.HPMEventReadValM[XLEN-1 -: 4] = {rd.of, rd.minh, rd.sinh, rd.uinh};
         end
      end
   end

`ifdef HPM_OVERFLOW_EN
   logic lcofiPending;
   logic mipWrite;

   assign mipWrite = hpm.CSRMWriteM && isMip && isM;

   // A fresh overflow outranks a same-cycle software clear
   always_ff @(posedge clk) begin
      if (reset)            lcofiPending <= 1'b0;
      else if (|firstWrap)  lcofiPending <= 1'b1;
      else if (mipWrite)    lcofiPending <= hpm.CSRWriteValM[LCOFI_BIT];
   end

   assign hpm.LCOFIPendingM = lcofiPending;
`else
   assign hpm.LCOFIPendingM = 1'b0;
`endif
endmodule

// File: tb/tb_hpmevent_ctrl.sv
// Randomised self-checking bench for hpmevent_ctrl against a behavioural model.
// Expectations follow HPM_OVERFLOW_EN in the same way as the design.
module tb_hpmevent_ctrl;
   localparam int XLEN       = 64;
   localparam int COUNTERS   = 32;
   localparam int NUM_EVENTS = 32;
`ifdef HPM_OVERFLOW_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hpmevent_ctrl_if #(.XLEN(XLEN), .COUNTERS(COUNTERS), .NUM_EVENTS(NUM_EVENTS)) hpm ();

   hpmevent_ctrl #(.XLEN(XLEN), .COUNTERS(COUNTERS), .NUM_EVENTS(NUM_EVENTS)) dut (
      .clk  (clk),
      .reset(reset),
      .hpm  (hpm)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Behavioural model of the architectural state
   int unsigned         mSel  [COUNTERS];
   bit                  mOf   [COUNTERS];
   bit                  mMinh [COUNTERS];
   bit                  mSinh [COUNTERS];
   bit                  mUinh [COUNTERS];
   bit                  mPend;
   logic [COUNTERS-1:0] mInc;

   function automatic bit inRange(logic [11:0] a);
      return (a >= 12'h323) && (int'(a) <= 32'h320 + COUNTERS - 1);
   endfunction

   function automatic logic [63:0] modelRead(logic [11:0] a, logic [1:0] p);
      int unsigned k;
      if (p != 2'd3 || !inRange(a)) return '0;
      k = int'(a) - 32'h320;
      return {mOf[k], mMinh[k], mSinh[k], mUinh[k], 60'(mSel[k])};
   endfunction

   function automatic bit modelIllegal(logic [11:0] a, logic [1:0] p);
      return (a != 12'h344) && !(p == 2'd3 && inRange(a));
   endfunction

   // Advance one clock: model takes the effect of current inputs, returns #1 after the edge
   task automatic cycle();
      logic [COUNTERS-1:0] nInc;
      bit                  newOv;
      bit                  inh;
      int unsigned         k;
      logic [63:0]         v;
      logic [11:0]         a;
      logic [1:0]          p;
      nInc  = '0;
      newOv = 1'b0;
      a     = hpm.CSRAdrM;
      p     = hpm.PrivilegeModeW;
      v     = hpm.CSRWriteValM;
      for (int i = 3; i < COUNTERS; i++) begin
         inh = OVF && ((p == 2'd3 && mMinh[i]) || (p == 2'd1 && mSinh[i]) || (p == 2'd0 && mUinh[i]));
         nInc[i] = (mSel[i] != 0) && hpm.RawEventM[mSel[i]] && !inh;
         if (OVF && hpm.CounterWrapM[i] && !mOf[i]) newOv = 1'b1;
      end
      if (hpm.CSRMWriteM && p == 2'd3 && inRange(a)) begin
         k = int'(a) - 32'h320;
         mSel[k] = (v[59:0] >= 60'(NUM_EVENTS)) ? 0 : int'(v[7:0]);
         if (OVF) begin
            mOf[k] = v[63]; mMinh[k] = v[62]; mSinh[k] = v[61]; mUinh[k] = v[60];
         end
      end
      for (int i = 3; i < COUNTERS; i++)
         if (OVF && hpm.CounterWrapM[i]) mOf[i] = 1'b1;
      if (newOv) mPend = 1'b1;
      else if (OVF && hpm.CSRMWriteM && p == 2'd3 && a == 12'h344) mPend = v[13];
      if (reset) begin
         for (int i = 0; i < COUNTERS; i++) begin
            mSel[i] = 0; mOf[i] = 0; mMinh[i] = 0; mSinh[i] = 0; mUinh[i] = 0;
         end
         mPend = 1'b0;
         nInc  = '0;
      end
      mInc = nInc;
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(logic [11:0] a, logic [63:0] v);
      hpm.CSRMWriteM   = 1'b1;
      hpm.CSRAdrM      = a;
      hpm.CSRWriteValM = v;
      cycle();
      hpm.CSRMWriteM   = 1'b0;
   endtask

   task automatic test_reset();
      hpm.CSRMWriteM = 1'b0; hpm.CSRAdrM = 12'h323; hpm.CSRWriteValM = '0;
      hpm.PrivilegeModeW = 2'd3; hpm.RawEventM = '0; hpm.CounterWrapM = '0;
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      checks++;
      if (hpm.HPMEventIncM !== '0) begin
         failures++; $display("FAIL reset_inc got=%h exp=0", hpm.HPMEventIncM);
      end
      checks++;
      if (hpm.LCOFIPendingM !== 1'b0) begin
         failures++; $display("FAIL reset_lcofi got=%b exp=0", hpm.LCOFIPendingM);
      end
      #1;
      checks++;
      if (hpm.HPMEventReadValM !== 64'h0 || hpm.IllegalHPMEventAccessM !== 1'b0) begin
         failures++; $display("FAIL reset_read got=%h/%b exp=0/0", hpm.HPMEventReadValM, hpm.IllegalHPMEventAccessM);
      end
   endtask

   task automatic test_route();
      hpm.PrivilegeModeW = 2'd3;
      csr_write(12'h326, 64'd5);
      hpm.RawEventM = 32'h20;
      cycle();
      hpm.RawEventM = '0;
      checks++;
      if (hpm.HPMEventIncM !== mInc) begin
         failures++; $display("FAIL route_inc got=%h exp=%h", hpm.HPMEventIncM, mInc);
      end
      cycle();
      checks++;
      if (hpm.HPMEventIncM !== mInc) begin
         failures++; $display("FAIL route_oneshot got=%h exp=%h", hpm.HPMEventIncM, mInc);
      end
   endtask

   task automatic test_inhibit();
      hpm.PrivilegeModeW = 2'd3;
      csr_write(12'h323, 64'h4000_0000_0000_0003);
      hpm.CSRAdrM = 12'h323; #1;
      checks++;
      if (hpm.HPMEventReadValM !== modelRead(12'h323, 2'd3)) begin
         failures++; $display("FAIL inh_readback got=%h exp=%h", hpm.HPMEventReadValM, modelRead(12'h323, 2'd3));
      end
      for (int m = 0; m < 2; m++) begin
         hpm.PrivilegeModeW = (m == 0) ? 2'd3 : 2'd0;
         hpm.RawEventM = 32'h8;
         cycle();
         hpm.RawEventM = '0;
         checks++;
         if (hpm.HPMEventIncM !== mInc) begin
            failures++; $display("FAIL inh_mode%0d got=%h exp=%h", m, hpm.HPMEventIncM, mInc);
         end
      end
      hpm.PrivilegeModeW = 2'd3;
   endtask

   task automatic test_warl();
      logic [11:0] adr [3] = '{12'h327, 12'h328, 12'h329};
      logic [63:0] val [3] = '{64'(NUM_EVENTS + 1), 64'h0000_0100_0000_0002, 64'(NUM_EVENTS - 1)};
      hpm.PrivilegeModeW = 2'd3;
      for (int i = 0; i < 3; i++) begin
         csr_write(adr[i], val[i]);
         hpm.CSRAdrM = adr[i]; #1;
         checks++;
         if (hpm.HPMEventReadValM !== modelRead(adr[i], 2'd3)) begin
            failures++; $display("FAIL warl_read%0d got=%h exp=%h", i, hpm.HPMEventReadValM, modelRead(adr[i], 2'd3));
         end
      end
      hpm.RawEventM = '1;
      cycle();
      hpm.RawEventM = '0;
      checks++;
      if (hpm.HPMEventIncM !== mInc) begin
         failures++; $display("FAIL warl_inc got=%h exp=%h", hpm.HPMEventIncM, mInc);
      end
   endtask

   task automatic test_overflow();
      hpm.PrivilegeModeW = 2'd3;
      hpm.CounterWrapM = 32'h10;
      cycle();
      hpm.CounterWrapM = '0;
      hpm.CSRAdrM = 12'h324; #1;
      checks++;
      if (hpm.LCOFIPendingM !== mPend || hpm.HPMEventReadValM !== modelRead(12'h324, 2'd3)) begin
         failures++; $display("FAIL of_first got=%b/%h exp=%b/%h", hpm.LCOFIPendingM, hpm.HPMEventReadValM, mPend, modelRead(12'h324, 2'd3));
      end
      csr_write(12'h344, 64'h0);
      checks++;
      if (hpm.LCOFIPendingM !== mPend) begin
         failures++; $display("FAIL of_mipclr got=%b exp=%b", hpm.LCOFIPendingM, mPend);
      end
      hpm.CounterWrapM = 32'h10;
      cycle();
      hpm.CounterWrapM = '0;
      checks++;
      if (hpm.LCOFIPendingM !== mPend) begin
         failures++; $display("FAIL of_rewrap got=%b exp=%b", hpm.LCOFIPendingM, mPend);
      end
      hpm.CounterWrapM = 32'h20;
      csr_write(12'h344, 64'h0);
      hpm.CounterWrapM = '0;
      checks++;
      if (hpm.LCOFIPendingM !== mPend) begin
         failures++; $display("FAIL of_mip_race got=%b exp=%b", hpm.LCOFIPendingM, mPend);
      end
      hpm.CounterWrapM = 32'h40;
      csr_write(12'h326, 64'h0000_0000_0000_0005);
      hpm.CounterWrapM = '0;
      hpm.CSRAdrM = 12'h326; #1;
      checks++;
      if (hpm.HPMEventReadValM !== modelRead(12'h326, 2'd3)) begin
         failures++; $display("FAIL of_csr_race got=%h exp=%h", hpm.HPMEventReadValM, modelRead(12'h326, 2'd3));
      end
   endtask

   task automatic test_access();
      logic [11:0] adr [6] = '{12'h323, 12'h322, 12'h33F, 12'h340, 12'h344, 12'h723};
      hpm.PrivilegeModeW = 2'd1;
      csr_write(12'h323, 64'h1F);
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 6; i++) begin
            hpm.PrivilegeModeW = 2'(p);
            hpm.CSRAdrM = adr[i]; #1;
            checks++;
            if (hpm.IllegalHPMEventAccessM !== modelIllegal(adr[i], 2'(p)) ||
                hpm.HPMEventReadValM !== modelRead(adr[i], 2'(p))) begin
               failures++;
               $display("FAIL access_p%0d_%h got=%b/%h exp=%b/%h", p, adr[i], hpm.IllegalHPMEventAccessM,
                        hpm.HPMEventReadValM, modelIllegal(adr[i], 2'(p)), modelRead(adr[i], 2'(p)));
            end
         end
      end
      hpm.PrivilegeModeW = 2'd3;
   endtask

   task automatic test_random();
      logic [11:0] a;
      for (int n = 0; n < 600; n++) begin
         hpm.PrivilegeModeW = 2'($urandom_range(0, 3));
         hpm.RawEventM      = $urandom;
         hpm.CounterWrapM   = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(3, 31)) : '0;
         a = ($urandom_range(0, 9) == 0) ? 12'h344 : 12'(32'h31E + $urandom_range(0, 36));
         hpm.CSRAdrM        = a;
         hpm.CSRMWriteM     = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 2))
            0:       hpm.CSRWriteValM = {$urandom, $urandom};
            1:       hpm.CSRWriteValM = {4'($urandom), 55'h0, 5'($urandom)};
            default: hpm.CSRWriteValM = {32'h0, 18'h0, 1'($urandom), 13'($urandom)};
         endcase
         #1;
         checks++;
         if (hpm.IllegalHPMEventAccessM !== modelIllegal(a, hpm.PrivilegeModeW) ||
             hpm.HPMEventReadValM !== modelRead(a, hpm.PrivilegeModeW)) begin
            failures++;
            $display("FAIL rand_read n=%0d adr=%h got=%b/%h exp=%b/%h", n, a, hpm.IllegalHPMEventAccessM,
                     hpm.HPMEventReadValM, modelIllegal(a, hpm.PrivilegeModeW), modelRead(a, hpm.PrivilegeModeW));
         end
         cycle();
         checks++;
         if (hpm.HPMEventIncM !== mInc || hpm.LCOFIPendingM !== mPend) begin
            failures++;
            $display("FAIL rand_out n=%0d got=%h/%b exp=%h/%b", n, hpm.HPMEventIncM, hpm.LCOFIPendingM, mInc, mPend);
         end
      end
      hpm.CSRMWriteM = 1'b0; hpm.CounterWrapM = '0; hpm.RawEventM = '0; hpm.PrivilegeModeW = 2'd3;
   endtask

   task automatic test_reset_midop();
      hpm.PrivilegeModeW = 2'd3;
      csr_write(12'h326, 64'd7);
      hpm.RawEventM    = '1;
      hpm.CounterWrapM = 32'hF0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      hpm.RawEventM    = '0;
      hpm.CounterWrapM = '0;
      hpm.CSRAdrM = 12'h326; #1;
      checks++;
      if (hpm.HPMEventIncM !== '0 || hpm.LCOFIPendingM !== 1'b0 || hpm.HPMEventReadValM !== 64'h0) begin
         failures++;
         $display("FAIL midop_reset got=%h/%b/%h exp=0/0/0", hpm.HPMEventIncM, hpm.LCOFIPendingM, hpm.HPMEventReadValM);
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_inhibit();
      test_warl();
      test_overflow();
      test_access();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
